// File: rtl/npc_pkg.sv
// Shared definitions for the NPC core control path: state encoding,
// well-known instruction words and the architectural reset PC.
package npc_pkg;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_FETCH = 3'd1;
    localparam logic [2:0] ST_FWAIT = 3'd2;
    localparam logic [2:0] ST_EXEC  = 3'd3;
    localparam logic [2:0] ST_MEM   = 3'd4;
    localparam logic [2:0] ST_MWAIT = 3'd5;
    localparam logic [2:0] ST_WB    = 3'd6;
    localparam logic [2:0] ST_HALT  = 3'd7;

    typedef enum logic [2:0] {
        S_IDLE  = ST_IDLE,
        S_FETCH = ST_FETCH,
        S_FWAIT = ST_FWAIT,
        S_EXEC  = ST_EXEC,
        S_MEM   = ST_MEM,
        S_MWAIT = ST_MWAIT,
        S_WB    = ST_WB,
        S_HALT  = ST_HALT
    } npc_state_e;

    localparam logic [31:0] INST_EBREAK  = 32'h00100073;
    localparam logic [31:0] NPC_RESET_PC = 32'h80000000;

    // States in which the sequencer is waiting on an external handshake
    // and therefore is guarded by the watchdog.
    function automatic logic is_wait_state(input npc_state_e s);
        return (s == S_FETCH) || (s == S_FWAIT) || (s == S_MEM) || (s == S_MWAIT);
    endfunction

endpackage

// File: rtl/npc_watchdog.sv
// Cycle counter guarding handshake wait states. Cleared on any state
// change, advanced while waiting; expire flags the last allowed cycle.
module npc_watchdog
    import npc_pkg::*;
#(
    parameter int TIMEOUT = 256,
    parameter int TO_W    = 9
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic inc,
    output logic expire
);

    logic [TO_W-1:0] cnt;

    // wait-cycle counter; clear has priority over increment
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc) begin
            cnt <= cnt + TO_W'(1);
        end
    end

    // last cycle in which the awaited handshake may still arrive
    assign expire = (cnt == TO_W'(TIMEOUT - 1));

endmodule

// File: rtl/npc_ctrl.sv
// Multi-cycle sequencer for the NPC core: fetch over valid/ready, hold the
// instruction, run an optional memory access, then commit PC/regfile.
//
// state  | meaning
// -------+---------------------------------------------------------------
// IDLE   | reset state, one cycle before the first fetch
// FETCH  | fetch request presented, waiting for ifu_req_ready
// FWAIT  | request accepted, waiting for ifu_rsp_valid; loads inst
// EXEC   | decode/ALU settle; picks ebreak halt, memory path or writeback
// MEM    | data request presented, waiting for lsu_req_ready
// MWAIT  | data request accepted, waiting for lsu_rsp_valid
// WB     | commit: pc_wen, reg_wen unless store, instret++
// HALT   | parked until reset (ebreak or watchdog expiry)
module npc_ctrl
    import npc_pkg::*;
#(
    parameter int TIMEOUT = 256,
    parameter int TO_W    = 9
) (
    input  logic        clk,
    input  logic        rst,
    output logic        ifu_req_valid,
    input  logic        ifu_req_ready,
    input  logic        ifu_rsp_valid,
    input  logic [31:0] ifu_rsp_data,
    output logic [31:0] inst,
    input  logic        is_load,
    input  logic        is_store,
    output logic        lsu_req_valid,
    input  logic        lsu_req_ready,
    input  logic        lsu_rsp_valid,
    output logic        pc_wen,
    output logic        reg_wen,
    output logic [31:0] instret,
    output logic        halt,
    output logic        halt_err
);

    npc_state_e state;
    npc_state_e state_nxt;
    logic       wd_expire;
    logic       wd_clr;
    logic       wd_inc;
    logic       halt_err_set;

    npc_watchdog #(
        .TIMEOUT (TIMEOUT),
        .TO_W    (TO_W)
    ) u_watchdog (
        .clk    (clk),
        .rst    (rst),
        .clr    (wd_clr),
        .inc    (wd_inc),
        .expire (wd_expire)
    );

    // state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // next-state decode and Moore strobes; a handshake in the final
    // watchdog cycle still wins over expiry
    always_comb begin
        state_nxt     = state;
        ifu_req_valid = 1'b0;
        lsu_req_valid = 1'b0;
        pc_wen        = 1'b0;
        reg_wen       = 1'b0;
        halt          = 1'b0;
        halt_err_set  = 1'b0;
        case (state)
            S_IDLE: begin
                state_nxt = S_FETCH;
            end
            S_FETCH: begin
                ifu_req_valid = 1'b1;
                if (ifu_req_ready) begin
                    state_nxt = S_FWAIT;
                end else if (wd_expire) begin
                    state_nxt    = S_HALT;
                    halt_err_set = 1'b1;
                end
            end
            S_FWAIT: begin
                if (ifu_rsp_valid) begin
                    state_nxt = S_EXEC;
                end else if (wd_expire) begin
                    state_nxt    = S_HALT;
                    halt_err_set = 1'b1;
                end
            end
            S_EXEC: begin
                if (inst == INST_EBREAK) begin
                    state_nxt = S_HALT;
                end else if (is_load || is_store) begin
                    state_nxt = S_MEM;
                end else begin
                    state_nxt = S_WB;
                end
            end
            S_MEM: begin
                lsu_req_valid = 1'b1;
                if (lsu_req_ready) begin
                    state_nxt = S_MWAIT;
                end else if (wd_expire) begin
                    state_nxt    = S_HALT;
                    halt_err_set = 1'b1;
                end
            end
            S_MWAIT: begin
                if (lsu_rsp_valid) begin
                    state_nxt = S_WB;
                end else if (wd_expire) begin
                    state_nxt    = S_HALT;
                    halt_err_set = 1'b1;
                end
            end
            S_WB: begin
                pc_wen    = 1'b1;
                reg_wen   = !is_store;
                state_nxt = S_FETCH;
            end
            S_HALT: begin
                halt = 1'b1;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    assign wd_clr = (state_nxt != state);
    assign wd_inc = is_wait_state(state);

    // instruction register, loaded only on the fetch response handshake
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            inst <= '0;
        end else if ((state == S_FWAIT) && ifu_rsp_valid) begin
            inst <= ifu_rsp_data;
        end
    end

    // retired-instruction counter, wraps naturally
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            instret <= '0;
        end else if (state == S_WB) begin
            instret <= instret + 32'd1;
        end
    end

    // sticky watchdog-halt flag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            halt_err <= 1'b0;
        end else if (halt_err_set) begin
            halt_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_npc_ctrl.sv
// Self-checking bench for npc_ctrl: a delay-programmable memory agent and a
// transaction-level timing model (latency = sum of per-phase wait cycles).
module tb_npc_ctrl;

    localparam int TO    = 8;
    localparam int NEVER = 100000;
    localparam logic [31:0] EBREAK = 32'h00100073;
    localparam logic [31:0] ADDI   = 32'h00500093;
    localparam logic [31:0] SW     = 32'h00102023;
    localparam logic [31:0] LW     = 32'h00002083;

    logic        clk = 1'b0;
    logic        rst;
    logic        ifu_req_valid;
    logic        ifu_req_ready;
    logic        ifu_rsp_valid;
    logic [31:0] ifu_rsp_data;
    logic [31:0] inst;
    logic        is_load;
    logic        is_store;
    logic        lsu_req_valid;
    logic        lsu_req_ready;
    logic        lsu_rsp_valid;
    logic        pc_wen;
    logic        reg_wen;
    logic [31:0] instret;
    logic        halt;
    logic        halt_err;

    int total = 0;
    int bad   = 0;
    int model_instret = 0;

    always #5 clk = ~clk;

    // minimal decoder standing in for the datapath
    assign is_load  = (inst[6:0] == 7'b0000011);
    assign is_store = (inst[6:0] == 7'b0100011);

    npc_ctrl #(.TIMEOUT(TO), .TO_W(4)) dut (
        .clk           (clk),
        .rst           (rst),
        .ifu_req_valid (ifu_req_valid),
        .ifu_req_ready (ifu_req_ready),
        .ifu_rsp_valid (ifu_rsp_valid),
        .ifu_rsp_data  (ifu_rsp_data),
        .inst          (inst),
        .is_load       (is_load),
        .is_store      (is_store),
        .lsu_req_valid (lsu_req_valid),
        .lsu_req_ready (lsu_req_ready),
        .lsu_rsp_valid (lsu_rsp_valid),
        .pc_wen        (pc_wen),
        .reg_wen       (reg_wen),
        .instret       (instret),
        .halt          (halt),
        .halt_err      (halt_err)
    );

    function automatic bit is_mem(input logic [31:0] ins);
        return (ins[6:0] == 7'b0000011) || (ins[6:0] == 7'b0100011);
    endfunction

    // cycles from first fetch-request cycle through the writeback cycle
    function automatic int exp_lat(input logic [31:0] ins, input int dq, dr, lq, lr);
        int l;
        l = (dq + 1) + (dr + 1) + 1 + 1;
        if (is_mem(ins)) l += (lq + 1) + (lr + 1);
        return l;
    endfunction

    task automatic idle_inputs();
        ifu_req_ready = 1'b0;
        ifu_rsp_valid = 1'b0;
        ifu_rsp_data  = '0;
        lsu_req_ready = 1'b0;
        lsu_rsp_valid = 1'b0;
    endtask

    // reset with no checks; returns positioned in the first FETCH cycle
    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        model_instret = 0;
        @(posedge clk);
        #1;
    endtask

    // Memory agent: withholds ready for dq/lq cycles of a request, answers
    // dr/lr cycles after acceptance (0 = next cycle). Runs until writeback,
    // halt, or max_cyc cycles. Called at posedge+1 of a FETCH cycle.
    task automatic run(input logic [31:0] ins, input int dq, dr, lq, lr, max_cyc,
                       output int lat, output int halt_idx, output int lsu_cyc,
                       output int pw_cnt, output logic rw, output logic [31:0] inst_wb);
        int  fcnt, lcnt, rc, lrc;
        bit  fpend, lpend, done;
        fcnt = 0; lcnt = 0; rc = 0; lrc = 0;
        fpend = 0; lpend = 0; done = 0;
        lat = -1; halt_idx = -1; lsu_cyc = 0; pw_cnt = 0; rw = 1'b0; inst_wb = '0;
        for (int n = 0; n < max_cyc && !done; n++) begin
            ifu_req_ready = 1'b0;
            ifu_rsp_valid = 1'b0;
            ifu_rsp_data  = $urandom;
            lsu_req_ready = 1'b0;
            lsu_rsp_valid = 1'b0;
            if (halt) begin
                halt_idx = n;
                done = 1;
            end else begin
                if (fpend) begin
                    if (rc == 0) begin
                        ifu_rsp_valid = 1'b1;
                        ifu_rsp_data  = ins;
                        fpend = 0;
                    end else rc--;
                end
                if (ifu_req_valid) begin
                    if (fcnt == dq) begin
                        ifu_req_ready = 1'b1;
                        fpend = 1;
                        rc = dr;
                    end
                    fcnt++;
                end
                if (lpend) begin
                    if (lrc == 0) begin
                        lsu_rsp_valid = 1'b1;
                        lpend = 0;
                    end else lrc--;
                end
                if (lsu_req_valid) begin
                    lsu_cyc++;
                    if (lcnt == lq) begin
                        lsu_req_ready = 1'b1;
                        lpend = 1;
                        lrc = lr;
                    end
                    lcnt++;
                end
                if (pc_wen) begin
                    pw_cnt++;
                    rw = reg_wen;
                    inst_wb = inst;
                    lat = n + 1;
                    done = 1;
                end
                @(posedge clk);
                #1;
            end
        end
        idle_inputs();
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b1;
        #3;
        total++;
        if ({ifu_req_valid, lsu_req_valid, pc_wen, reg_wen, halt, halt_err} !== 6'b0) begin
            bad++;
            $display("FAIL reset_strobes: got %b want 000000",
                     {ifu_req_valid, lsu_req_valid, pc_wen, reg_wen, halt, halt_err});
        end
        total++;
        if (instret !== 32'd0 || inst !== 32'd0) begin
            bad++;
            $display("FAIL reset_regs: instret=%0h inst=%0h want 0/0", instret, inst);
        end
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        model_instret = 0;
        total++;
        if (ifu_req_valid !== 1'b0) begin
            bad++;
            $display("FAIL idle_cycle: ifu_req_valid=%b want 0", ifu_req_valid);
        end
        @(posedge clk);
        #1;
        total++;
        if (ifu_req_valid !== 1'b1) begin
            bad++;
            $display("FAIL fetch_cycle1: ifu_req_valid=%b want 1", ifu_req_valid);
        end
    endtask

    task automatic test_addi();
        int lat, hi, lc, pw;
        logic rw;
        logic [31:0] iw;
        run(ADDI, 0, 0, 0, 0, 100, lat, hi, lc, pw, rw, iw);
        model_instret++;
        total++;
        if (lat !== 4) begin
            bad++;
            $display("FAIL addi_latency: got %0d want 4", lat);
        end
        total++;
        if (rw !== 1'b1 || pw !== 1 || lc !== 0) begin
            bad++;
            $display("FAIL addi_strobes: reg_wen=%b pc_wen_cnt=%0d lsu_cyc=%0d want 1/1/0", rw, pw, lc);
        end
        total++;
        if (instret !== 32'(model_instret) || ifu_req_valid !== 1'b1) begin
            bad++;
            $display("FAIL addi_instret: instret=%0d refetch=%b want %0d/1", instret, ifu_req_valid, model_instret);
        end
    endtask

    task automatic test_store();
        int lat, hi, lc, pw;
        logic rw;
        logic [31:0] iw;
        run(SW, 0, 0, 3, 0, 100, lat, hi, lc, pw, rw, iw);
        model_instret++;
        total++;
        if (lc !== 4) begin
            bad++;
            $display("FAIL store_mem_cycles: got %0d want 4", lc);
        end
        total++;
        if (rw !== 1'b0 || pw !== 1) begin
            bad++;
            $display("FAIL store_wb: reg_wen=%b pc_wen_cnt=%0d want 0/1", rw, pw);
        end
        total++;
        if (lat !== exp_lat(SW, 0, 0, 3, 0) || instret !== 32'(model_instret)) begin
            bad++;
            $display("FAIL store_latency: lat=%0d instret=%0d want %0d/%0d",
                     lat, instret, exp_lat(SW, 0, 0, 3, 0), model_instret);
        end
    endtask

    task automatic test_random();
        int lat, hi, lc, pw, dq, dr, lq, lr, kind, exp_lc;
        logic rw;
        logic [31:0] iw, ins;
        for (int k = 0; k < 30; k++) begin
            kind = $urandom_range(0, 2);
            ins  = $urandom;
            case (kind)
                0:       ins[6:0] = 7'b0010011;
                1:       ins[6:0] = 7'b0000011;
                default: ins[6:0] = 7'b0100011;
            endcase
            dq = $urandom_range(0, TO - 1);
            dr = $urandom_range(0, TO - 1);
            lq = $urandom_range(0, TO - 1);
            lr = $urandom_range(0, TO - 1);
            run(ins, dq, dr, lq, lr, 200, lat, hi, lc, pw, rw, iw);
            model_instret++;
            exp_lc = is_mem(ins) ? lq + 1 : 0;
            total++;
            if (lat !== exp_lat(ins, dq, dr, lq, lr) || lc !== exp_lc) begin
                bad++;
                $display("FAIL rand_timing[%0d]: lat=%0d lsu_cyc=%0d want %0d/%0d",
                         k, lat, lc, exp_lat(ins, dq, dr, lq, lr), exp_lc);
            end
            total++;
            if (iw !== ins || rw !== (kind != 2) || pw !== 1) begin
                bad++;
                $display("FAIL rand_wb[%0d]: inst=%h reg_wen=%b pc_wen_cnt=%0d want %h/%b/1",
                         k, iw, rw, pw, ins, (kind != 2));
            end
            total++;
            if (instret !== 32'(model_instret) || halt !== 1'b0 || ifu_req_valid !== 1'b1) begin
                bad++;
                $display("FAIL rand_retire[%0d]: instret=%0d halt=%b refetch=%b want %0d/0/1",
                         k, instret, halt, ifu_req_valid, model_instret);
            end
        end
    endtask

    task automatic test_last_cycle();
        int lat, hi, lc, pw;
        logic rw;
        logic [31:0] iw;
        run(LW, TO - 1, TO - 1, TO - 1, TO - 1, 200, lat, hi, lc, pw, rw, iw);
        model_instret++;
        total++;
        if (lat !== exp_lat(LW, TO - 1, TO - 1, TO - 1, TO - 1) || hi !== -1) begin
            bad++;
            $display("FAIL last_cycle_handshake: lat=%0d halt_idx=%0d want %0d/-1",
                     lat, hi, exp_lat(LW, TO - 1, TO - 1, TO - 1, TO - 1));
        end
        total++;
        if (halt !== 1'b0 || instret !== 32'(model_instret)) begin
            bad++;
            $display("FAIL last_cycle_state: halt=%b instret=%0d want 0/%0d", halt, instret, model_instret);
        end
    endtask

    task automatic test_reset_mid();
        int lat, hi, lc, pw;
        logic rw;
        logic [31:0] iw;
        // FETCH, FWAIT, EXEC, MEM, MWAIT, MWAIT -> now in MWAIT
        run(LW, 0, 0, 0, NEVER, 6, lat, hi, lc, pw, rw, iw);
        total++;
        if (lc !== 1 || pw !== 0 || inst !== LW) begin
            bad++;
            $display("FAIL mid_setup: lsu_cyc=%0d pc_wen_cnt=%0d inst=%h want 1/0/%h", lc, pw, inst, LW);
        end
        #3;
        rst = 1'b1;
        #1;
        total++;
        if ({ifu_req_valid, lsu_req_valid, pc_wen, reg_wen, halt, halt_err} !== 6'b0 ||
            inst !== 32'd0 || instret !== 32'd0) begin
            bad++;
            $display("FAIL mid_reset_async: strobes=%b inst=%h instret=%0d want 0/0/0",
                     {ifu_req_valid, lsu_req_valid, pc_wen, reg_wen, halt, halt_err}, inst, instret);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_instret = 0;
        total++;
        if (ifu_req_valid !== 1'b0) begin
            bad++;
            $display("FAIL mid_idle: ifu_req_valid=%b want 0", ifu_req_valid);
        end
        @(posedge clk);
        #1;
        total++;
        if (ifu_req_valid !== 1'b1) begin
            bad++;
            $display("FAIL mid_refetch: ifu_req_valid=%b want 1", ifu_req_valid);
        end
        run(ADDI, 0, 0, 0, 0, 100, lat, hi, lc, pw, rw, iw);
        model_instret++;
        total++;
        if (lat !== 4 || instret !== 32'(model_instret)) begin
            bad++;
            $display("FAIL mid_recover: lat=%0d instret=%0d want 4/%0d", lat, instret, model_instret);
        end
    endtask

    task automatic test_ebreak();
        int lat, hi, lc, pw, viol;
        logic rw;
        logic [31:0] iw;
        do_reset();
        run(EBREAK, 0, 0, 0, 0, 60, lat, hi, lc, pw, rw, iw);
        total++;
        if (hi !== 3 || pw !== 0) begin
            bad++;
            $display("FAIL ebreak_halt: halt_idx=%0d pc_wen_cnt=%0d want 3/0", hi, pw);
        end
        total++;
        if (halt_err !== 1'b0 || instret !== 32'd0) begin
            bad++;
            $display("FAIL ebreak_err: halt_err=%b instret=%0d want 0/0", halt_err, instret);
        end
        viol = 0;
        for (int i = 0; i < 20; i++) begin
            if (ifu_req_valid !== 1'b0 || halt !== 1'b1 || pc_wen !== 1'b0 || lsu_req_valid !== 1'b0) viol++;
            @(posedge clk);
            #1;
        end
        total++;
        if (viol !== 0) begin
            bad++;
            $display("FAIL ebreak_parked: %0d bad cycles, want 0", viol);
        end
    endtask

    task automatic test_timeouts();
        int lat, hi, lc, pw;
        logic rw;
        logic [31:0] iw;
        // response never arrives: 8 FWAIT cycles, HALT at index 9
        do_reset();
        run(ADDI, 0, NEVER, 0, 0, 60, lat, hi, lc, pw, rw, iw);
        total++;
        if (hi !== 1 + TO || halt_err !== 1'b1 || pw !== 0) begin
            bad++;
            $display("FAIL fwait_timeout: halt_idx=%0d halt_err=%b pc_wen_cnt=%0d want %0d/1/0",
                     hi, halt_err, pw, 1 + TO);
        end
        // request never accepted
        do_reset();
        run(ADDI, NEVER, 0, 0, 0, 60, lat, hi, lc, pw, rw, iw);
        total++;
        if (hi !== TO || halt_err !== 1'b1) begin
            bad++;
            $display("FAIL fetch_timeout: halt_idx=%0d halt_err=%b want %0d/1", hi, halt_err, TO);
        end
        // data request never accepted
        do_reset();
        run(SW, 0, 0, NEVER, 0, 60, lat, hi, lc, pw, rw, iw);
        total++;
        if (hi !== 3 + TO || lc !== TO || halt_err !== 1'b1) begin
            bad++;
            $display("FAIL mem_timeout: halt_idx=%0d lsu_cyc=%0d halt_err=%b want %0d/%0d/1",
                     hi, lc, halt_err, 3 + TO, TO);
        end
        // data response never arrives
        do_reset();
        run(LW, 0, 0, 0, NEVER, 60, lat, hi, lc, pw, rw, iw);
        total++;
        if (hi !== 4 + TO || halt_err !== 1'b1 || halt !== 1'b1) begin
            bad++;
            $display("FAIL mwait_timeout: halt_idx=%0d halt_err=%b halt=%b want %0d/1/1",
                     hi, halt_err, halt, 4 + TO);
        end
    endtask

    initial begin
        test_reset();
        test_addi();
        test_store();
        test_random();
        test_last_cycle();
        test_reset_mid();
        test_ebreak();
        test_timeouts();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
